mux_scan_sequencer: RTL and testbench
=====================================

# mux_scan_sequencer

Upstream driver and capture stage for the 4:1 select-mux (`decoder`). Accepts a 4-bit word over a valid/ready handshake, presents it on the mux data inputs, and steps the mux select from 3 down to 0, holding each value for a programmable number of cycles. It samples the mux output at the end of each step and rebuilds the word MSB-first for a downstream valid/ready consumer. Optionally flags any difference between the word sent and the word captured.

## Interface
- `HOLD_CYCLES`, 2, number of clock cycles each select value is held; legal range 1..255; 0 is illegal.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word; high only in IDLE.
- `in_data`  in  4  word to scan.
- `mux_a`  out  4  drives mux `A`.
- `mux_sel`  out  2  drives mux `sel`.
- `mux_y`  in  1  mux `Y`; combinational from `mux_a`/`mux_sel`.
- `out_valid`  out  1  captured word valid.
- `out_ready`  in  1  downstream accepts the captured word.
- `out_data`  out  4  captured word; bit i = `mux_y` sampled while `mux_sel` = i.
- `busy`  out  1  high in SCAN or DONE.
- `mismatch`  out  1  `out_data` != loaded word; valid while `out_valid` is high (see Configuration).

## Operation
- Reset values: state IDLE, `in_ready`=1, `mux_a`=4'b0000, `mux_sel`=2'b11, `out_valid`=0, `out_data`=4'b0000, `busy`=0, `mismatch`=0, hold counter 0.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: register `in_data` into `mux_a` and a shadow copy, clear `out_data`, set `mux_sel`=3, clear the hold counter, and go to SCAN.
- **SCAN**
  - The hold counter increments each cycle.
  - On the cycle where counter = `HOLD_CYCLES`-1, write `mux_y` into `out_data[mux_sel]`.
    - If `mux_sel`≠0: decrement `mux_sel` and clear the counter.
    - If `mux_sel`=0: go to DONE.
  - `mux_a` is stable for the whole scan.
- **DONE**
  - `out_valid`=1.
  - `out_data` and `mismatch` are held stable until `out_valid && out_ready`. On that handshake go to IDLE, with `mux_sel` back at 3.
  - `out_valid` never drops without a handshake.
- `in_valid` is ignored outside IDLE, because `in_ready`=0.
- In IDLE, `mux_a` and `out_data` keep their last values.
- `busy` = (state≠IDLE).
- The hold counter is sized `$clog2(HOLD_CYCLES+1)` bits and never wraps within a step.
- `mux_sel` never decrements below 0; the 0 step always ends in DONE.
- **Reset mid-operation:** the in-flight word is discarded and every output returns to its reset value at the next edge, including `out_valid`, even if `out_ready` is low.

## Timing
- Input accepted at edge t. From edge t+1:
  - `mux_sel`=3 for cycles t+1 .. t+HOLD_CYCLES.
  - Then 2, then 1, then 0, each for HOLD_CYCLES cycles.
- `mux_y` is sampled at the last edge of each step, so the mux has HOLD_CYCLES−1 full cycles plus one to settle.
- `out_valid` rises at edge t+1+4·HOLD_CYCLES.
- The earliest next acceptance is one cycle after the output handshake; back-to-back throughput is 4·HOLD_CYCLES+2 cycles per word.
- `out_ready` held high in DONE gives a 1-cycle `out_valid` pulse.

## Configuration
- `MUX_SCAN_CHECK_EN` defined:
  - Compare `out_data` against the shadow copy.
  - `mismatch` is registered on entry to DONE and held through DONE.
  - `mismatch` clears on the output handshake and on reset.
- Not defined:
  - The shadow copy and comparator are not built.
  - `mismatch` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then idle, with HOLD_CYCLES=2 → `in_ready`=1, `mux_sel`=3, `out_valid`=0, `mux_a`=0.
- Ideal mux connected, send 4'b1010 with `out_ready`=1:
  - `mux_sel` steps 3,3,2,2,1,1,0,0.
  - `out_valid` rises 9 cycles after acceptance.
  - `out_data`=4'b1010, `mismatch`=0.
- Sequence 4'b0011 then 4'b0110 with `out_ready` low for 5 cycles in DONE:
  - `out_data`=4'b0011 is held stable.
  - `in_ready`=0 throughout, and `in_valid` is ignored.
  - The second word yields 4'b0110.
- `mux_y` stuck at 0 with the macro defined, send 4'b1010 → `out_data`=4'b0000, `mismatch`=1.
  - Same stimulus without the macro → `mismatch`=0.
- Assert `rst` during SCAN while `mux_sel`=1 → at the next edge all outputs return to reset values. A new 4'b0110 then scans cleanly.
- HOLD_CYCLES=1 with ideal mux, send 4'b1111 → `out_valid` rises 5 cycles after acceptance, `out_data`=4'b1111.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Purpose : drives a 4:1 select-mux with a 4-bit word, walks mux_sel 3->0 and rebuilds the word from mux_y.
// Latency : word accepted in cycle c, captured word valid in cycle c+1+4*HOLD_CYCLES.
// Backpressure: in_ready is high only in IDLE; the captured word is held in DONE until out_ready.
//
// Ports:
//   clk, rst               single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data    upstream 4-bit word handshake
//   mux_a, mux_sel         drive the mux data inputs and select
//   mux_y                  mux output (combinational from mux_a/mux_sel)
//   out_valid/out_ready/out_data downstream captured-word handshake
//   busy                   high while scanning or holding a result
//   mismatch               captured word differs from the loaded word
//                          (built only with MUX_SCAN_CHECK_EN defined, else tied 0)
//
// Parameter HOLD_CYCLES: cycles each select value is held, legal 1..255.
// Optional feature macro: MUX_SCAN_CHECK_EN.

module mux_scan_sequencer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [3:0] mux_a,
    output logic [1:0] mux_sel,
    input  logic       mux_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       busy,
    output logic       mismatch
);

    // Counter reaches HOLD_CYCLES on the final step (it increments on the
    // DONE-entry edge), so it needs one value beyond HOLD_CYCLES-1.
    localparam int              CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [3:0]       mux_a_q,    mux_a_d;
    logic [1:0]       mux_sel_q,  mux_sel_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [3:0]       out_data_q, out_data_d;

`ifdef MUX_SCAN_CHECK_EN
    logic [3:0]       shadow_q,   shadow_d;
    logic             mismatch_q, mismatch_d;
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mux_a_d    = mux_a_q;
        mux_sel_d  = mux_sel_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
`ifdef MUX_SCAN_CHECK_EN
        shadow_d   = shadow_q;
        mismatch_d = mismatch_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mux_a_d    = in_data;
                    out_data_d = 4'b0000;
                    mux_sel_d  = 2'd3;
                    cnt_d      = '0;
                    state_d    = ST_SCAN;
`ifdef MUX_SCAN_CHECK_EN
                    shadow_d   = in_data;
`endif
                end
            end

            ST_SCAN: begin
                cnt_d = cnt_q + CNT_ONE;
                // Sample on the last cycle of the step so the mux has had
                // the whole hold window to settle.
                if (cnt_q == CNT_LAST) begin
                    out_data_d[mux_sel_q] = mux_y;
                    if (mux_sel_q != 2'd0) begin
                        mux_sel_d = mux_sel_q - 2'd1;
                        cnt_d     = '0;
                    end else begin
                        state_d = ST_DONE;
`ifdef MUX_SCAN_CHECK_EN
                        // out_data_d already holds the final bit here.
                        mismatch_d = (out_data_d != shadow_q);
`endif
                    end
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    mux_sel_d = 2'd3;
                    cnt_d     = '0;
`ifdef MUX_SCAN_CHECK_EN
                    mismatch_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mux_sel_d = 2'd3;
                cnt_d     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mux_a_q    <= 4'b0000;
            mux_sel_q  <= 2'd3;
            cnt_q      <= '0;
            out_data_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            mux_a_q    <= mux_a_d;
            mux_sel_q  <= mux_sel_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef MUX_SCAN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= 4'b0000;
            mismatch_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign mux_a     = mux_a_q;
    assign mux_sel   = mux_sel_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Purpose : directed bench for mux_scan_sequencer with an ideal (optionally stuck-at-0) mux model.
// Latency : expects the captured word 4*HOLD_CYCLES+1 cycles after acceptance.
// Backpressure: exercises out_ready held low in DONE and in_valid asserted while busy.

module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    // HOLD_CYCLES = 2 instance
    logic       in_valid0, in_ready0, out_valid0, out_ready0, busy0, mismatch0, mux_y0;
    logic [3:0] in_data0, mux_a0, out_data0;
    logic [1:0] mux_sel0;

    // HOLD_CYCLES = 1 instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1, mismatch1, mux_y1;
    logic [3:0] in_data1, mux_a1, out_data1;
    logic [1:0] mux_sel1;

    logic       stuck = 1'b0;

    assign mux_y0 = stuck ? 1'b0 : mux_a0[mux_sel0];
    assign mux_y1 = mux_a1[mux_sel1];

    mux_scan_sequencer #(.HOLD_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .mux_a(mux_a0), .mux_sel(mux_sel0), .mux_y(mux_y0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .busy(busy0), .mismatch(mismatch0)
    );

    mux_scan_sequencer #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .mux_a(mux_a1), .mux_sel(mux_sel1), .mux_y(mux_y1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1), .mismatch(mismatch1)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         n;
    logic [4:0] sb[$];   // {mismatch, data} expected for each accepted word

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_in_ready",  in_ready0,  8'd1);
        chk("rst_mux_sel",   mux_sel0,   8'd3);
        chk("rst_out_valid", out_valid0, 8'd0);
        chk("rst_mux_a",     mux_a0,     8'd0);
        chk("rst_out_data",  out_data0,  8'd0);
        chk("rst_busy",      busy0,      8'd0);
        chk("rst_mismatch",  mismatch0,  8'd0);
    endtask

    // Called at a negedge with DUT0 idle; returns at the negedge of the
    // first scan cycle.
    task automatic accept0(input logic [3:0] w);
        logic [3:0] e;
        e = stuck ? 4'b0000 : w;
        chk("acc_in_ready", in_ready0, 8'd1);
        sb.push_back({(CHK && (e != w)), e});
        in_valid0 = 1'b1;
        in_data0  = w;
        @(negedge clk);
        in_valid0 = 1'b0;
    endtask

    task automatic wait_out0(output int cyc);
        cyc = 1;
        while (out_valid0 !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take0();
        logic [4:0] e;
        chk("take_out_valid", out_valid0, 8'd1);
        chk("sb_nonempty", 8'(sb.size() != 0), 8'd1);
        e = (sb.size() != 0) ? sb.pop_front() : 5'h1f;
        chk("out_data", out_data0, 8'(e[3:0]));
        chk("mismatch", mismatch0, 8'(e[4]));
        out_ready0 = 1'b1;
        @(negedge clk);
        out_ready0 = 1'b0;
        chk("post_hs_valid",    out_valid0, 8'd0);
        chk("post_hs_in_ready", in_ready0,  8'd1);
        chk("post_hs_sel",      mux_sel0,   8'd3);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid0  = 1'b0; in_data0 = 4'b0000; out_ready0 = 1'b0;
        in_valid1  = 1'b0; in_data1 = 4'b0000; out_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset / idle
        check_reset_state();
        chk("rst1_in_ready", in_ready1, 8'd1);
        chk("rst1_mux_sel",  mux_sel1,  8'd3);

        // 1010 with out_ready high: select walk and 9-cycle latency
        out_ready0 = 1'b1;
        accept0(4'b1010);
        for (int k = 0; k < 8; k++) begin
            chk("step_sel",   mux_sel0,   8'(3 - k / 2));
            chk("step_valid", out_valid0, 8'd0);
            chk("step_mux_a", mux_a0,     8'b1010);
            @(negedge clk);
        end
        chk("lat9_valid", out_valid0, 8'd1);
        take0();

        // 0011 held in DONE for 5 cycles, in_valid ignored meanwhile
        accept0(4'b0011);
        wait_out0(n);
        chk("lat_0011", 8'(n), 8'd9);
        for (int i = 0; i < 5; i++) begin
            chk("hold_data",     out_data0,  8'b0011);
            chk("hold_valid",    out_valid0, 8'd1);
            chk("hold_in_ready", in_ready0,  8'd0);
            chk("hold_mux_a",    mux_a0,     8'b0011);
            in_valid0 = 1'b1;
            in_data0  = 4'b0110;
            @(negedge clk);
        end
        in_valid0 = 1'b0;
        take0();
        accept0(4'b0110);
        wait_out0(n);
        chk("lat_0110", 8'(n), 8'd9);
        take0();

        // mux_y stuck at 0
        stuck = 1'b1;
        accept0(4'b1010);
        wait_out0(n);
        take0();
        stuck = 1'b0;

        // Reset while mux_sel = 1
        accept0(4'b0110);
        n = 0;
        while (mux_sel0 !== 2'd1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sel1", mux_sel0, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_reset_state();
        accept0(4'b0110);
        wait_out0(n);
        chk("lat_after_rst", 8'(n), 8'd9);
        take0();

        // HOLD_CYCLES = 1, 1111
        chk("d1_in_ready", in_ready1, 8'd1);
        in_valid1 = 1'b1;
        in_data1  = 4'b1111;
        @(negedge clk);
        in_valid1 = 1'b0;
        n = 1;
        while (out_valid1 !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("d1_latency",  8'(n),      8'd5);
        chk("d1_out_data", out_data1,  8'b1111);
        chk("d1_mismatch", mismatch1,  8'd0);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("d1_post_valid", out_valid1, 8'd0);
        chk("d1_post_sel",   mux_sel1,   8'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
